// File: rtl/sram_arb_pkg.sv
// Shared constants and FSM state type for the SRAM arbiter.
// Build option SRAM_ARB_RR_EN selects round-robin (defined) or fixed-priority arbitration.
package sram_arb_pkg;
    localparam int SRAM_ADDR_W      = 18;
    localparam int SRAM_DATA_W      = 16;
    localparam int SRAM_RD_LATENCY  = 2;
    localparam int MAX_LOCK_DEFAULT = 64;
    localparam int LOCK_CNT_W       = 7;

    typedef enum logic [0:0] {
        S_ARB_IDLE  = 1'b0,
        S_ARB_OWNED = 1'b1
    } arb_state_t;
endpackage

// File: rtl/sram_arb_select.sv
// Winner selection for unlocked arbitration: search starts at 'start', demoted requesters
// are only considered when nobody else is asking.
module sram_arb_select #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] demote,
    input  logic [IDX_W-1:0]   start,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);
    logic [NUM_REQ-1:0] cand;
    logic               found;
    int                 j;

    always_comb begin
        cand = req & ~demote;
        if (cand == '0) cand = req;
        valid = |cand;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(start) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && cand[IDX_W'(j)]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/sram_arbiter.sv
// Multi-requester SRAM arbiter with lock bursts, starvation release and read-tag pipeline.
// Define SRAM_ARB_RR_EN for round-robin unlocked arbitration; default is fixed priority.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int MAX_LOCK = MAX_LOCK_DEFAULT
) (
    input  logic                                   Clock_50,
    input  logic                                   Reset,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [NUM_REQ-1:0]                     lock,
    input  logic [NUM_REQ-1:0]                     we_n,
    input  logic [NUM_REQ-1:0][SRAM_ADDR_W-1:0]    addr,
    input  logic [NUM_REQ-1:0][SRAM_DATA_W-1:0]    wdata,
    output logic [NUM_REQ-1:0]                     gnt,
    output logic [NUM_REQ-1:0]                     rd_valid,
    output logic [SRAM_ADDR_W-1:0]                 SRAM_address,
    output logic [SRAM_DATA_W-1:0]                 SRAM_write_data,
    output logic                                   SRAM_we_n,
    input  logic [SRAM_DATA_W-1:0]                 SRAM_read_data
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);

    arb_state_t                    state_q, state_d;
    logic [LOCK_CNT_W-1:0]         lock_cnt_q, lock_cnt_d;
    logic [IDX_W-1:0]              owner_q, owner_d;
    logic [NUM_REQ-1:0]            gnt_q, gnt_d;
    logic [IDX_W-1:0]              gnt_idx_q, gnt_idx_d;
    logic [SRAM_ADDR_W-1:0]        sram_addr_q, sram_addr_d;
    logic [SRAM_DATA_W-1:0]        sram_wdata_q, sram_wdata_d;
    logic                          sram_we_n_q, sram_we_n_d;
    logic [SRAM_RD_LATENCY-1:0]    vld_pipe_q, vld_pipe_d;
    logic [SRAM_RD_LATENCY-1:0][IDX_W-1:0] id_pipe_q, id_pipe_d;

    logic [NUM_REQ-1:0] owner_oh, demote;
    logic               keep_owner, force_rel;
    logic               sel_valid, win_valid;
    logic [IDX_W-1:0]   sel_idx, win_idx, rr_ptr;

    // Read data goes straight to the requesters; rd_valid tells them whose it is.
    logic unused_rd_data;
    assign unused_rd_data = ^SRAM_read_data;

    always_comb begin
        owner_oh = '0;
        owner_oh[owner_q] = 1'b1;
    end

    assign keep_owner = (state_q == S_ARB_OWNED) && req[owner_q] && lock[owner_q];
    assign force_rel  = keep_owner && (lock_cnt_q >= MAX_LOCK_C) && |(req & ~owner_oh);
    assign demote     = force_rel ? owner_oh : '0;

    sram_arb_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_select (
        .req    (req),
        .demote (demote),
        .start  (rr_ptr),
        .valid  (sel_valid),
        .idx    (sel_idx)
    );

    always_comb begin
        state_d    = S_ARB_IDLE;
        lock_cnt_d = '0;
        owner_d    = owner_q;
        win_valid  = sel_valid;
        win_idx    = sel_idx;
        if (keep_owner && !force_rel) begin
            win_valid  = 1'b1;
            win_idx    = owner_q;
            state_d    = S_ARB_OWNED;
            lock_cnt_d = (lock_cnt_q >= MAX_LOCK_C) ? lock_cnt_q : lock_cnt_q + 1'b1;
        end else if (sel_valid && lock[sel_idx]) begin
            state_d    = S_ARB_OWNED;
            owner_d    = sel_idx;
            lock_cnt_d = LOCK_CNT_W'(1);
        end
    end

`ifdef SRAM_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (win_valid) rr_ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = '0;
`endif

    // Idle cycles keep the address/data stable and only deassert the write strobe.
    always_comb begin
        gnt_d        = '0;
        gnt_idx_d    = gnt_idx_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_we_n_d  = 1'b1;
        if (win_valid) begin
            gnt_d[win_idx] = 1'b1;
            gnt_idx_d      = win_idx;
            sram_addr_d    = addr[win_idx];
            sram_wdata_d   = wdata[win_idx];
            sram_we_n_d    = we_n[win_idx];
        end
    end

    // Stage 0 is loaded from the access currently on the bus, so the last stage lines up
    // with the SRAM read latency.
    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        id_pipe_d     = id_pipe_q;
        vld_pipe_d[0] = (|gnt_q) & sram_we_n_q;
        id_pipe_d[0]  = gnt_idx_q;
        for (int k = 1; k < SRAM_RD_LATENCY; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            id_pipe_d[k]  = id_pipe_q[k-1];
        end
    end

    always_comb begin
        rd_valid = '0;
        if (vld_pipe_q[SRAM_RD_LATENCY-1]) rd_valid[id_pipe_q[SRAM_RD_LATENCY-1]] = 1'b1;
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state_q      <= S_ARB_IDLE;
            lock_cnt_q   <= '0;
            owner_q      <= '0;
            gnt_q        <= '0;
            gnt_idx_q    <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_n_q  <= 1'b1;
            vld_pipe_q   <= '0;
            id_pipe_q    <= '0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            owner_q      <= owner_d;
            gnt_q        <= gnt_d;
            gnt_idx_q    <= gnt_idx_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_n_q  <= sram_we_n_d;
            vld_pipe_q   <= vld_pipe_d;
            id_pipe_q    <= id_pipe_d;
        end
    end

    assign gnt             = gnt_q;
    assign SRAM_address    = sram_addr_q;
    assign SRAM_write_data = sram_wdata_q;
    assign SRAM_we_n       = sram_we_n_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: vector table plus lock-burst, starvation and reset sequences.
module tb_sram_arbiter;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [17:0] A0 = 18'h00010;
    localparam logic [17:0] A1 = 18'h00100;
    localparam logic [17:0] A2 = 18'd146944;
    localparam logic [15:0] W0 = 16'h1111;
    localparam logic [15:0] W1 = 16'h2222;
    localparam logic [15:0] W2 = 16'hABCD;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [2:0]  we_n;
        logic [2:0]  exp_gnt;
        logic [2:0]  exp_rdv;
        logic        exp_we_n;
        logic [17:0] exp_addr;
        logic [15:0] exp_wdata;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      req, lock, we_n, gnt, rd_valid;
    logic [2:0][17:0] addr;
    logic [2:0][15:0] wdata;
    logic [17:0]     sram_addr;
    logic [15:0]     sram_wdata, sram_rdata;
    logic            sram_we_n;

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t vecs[19];

    always #5 clk = ~clk;

    sram_arbiter dut (
        .Clock_50        (clk),
        .Reset           (rst),
        .req             (req),
        .lock            (lock),
        .we_n            (we_n),
        .addr            (addr),
        .wdata           (wdata),
        .gnt             (gnt),
        .rd_valid        (rd_valid),
        .SRAM_address    (sram_addr),
        .SRAM_write_data (sram_wdata),
        .SRAM_we_n       (sram_we_n),
        .SRAM_read_data  (sram_rdata)
    );

    function automatic vec_t mk(logic r, logic [2:0] rq, logic [2:0] wn, logic [2:0] eg,
                                logic [2:0] erv, logic ewn, logic [17:0] ea, logic [15:0] ew);
        vec_t v;
        v.rst = r; v.req = rq; v.we_n = wn; v.exp_gnt = eg; v.exp_rdv = erv;
        v.exp_we_n = ewn; v.exp_addr = ea; v.exp_wdata = ew;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n1, bad_oh;
        bit saw0;
        rst = 1'b1; req = '0; lock = '0; we_n = 3'b111; sram_rdata = 16'h5A5A;
        addr[0] = A0; addr[1] = A1; addr[2] = A2;
        wdata[0] = W0; wdata[1] = W1; wdata[2] = W2;

        vecs[0]  = mk(1, 3'b000, 3'b111, 3'b000, 3'b000, 1, 18'h0, 16'h0);
        vecs[1]  = mk(0, 3'b000, 3'b111, 3'b000, 3'b000, 1, 18'h0, 16'h0);
        vecs[2]  = mk(0, 3'b010, 3'b111, 3'b010, 3'b000, 1, A1, W1);
        vecs[3]  = mk(0, 3'b000, 3'b111, 3'b000, 3'b000, 1, A1, W1);
        vecs[4]  = mk(0, 3'b000, 3'b111, 3'b000, 3'b010, 1, A1, W1);
        vecs[5]  = mk(0, 3'b100, 3'b011, 3'b100, 3'b000, 0, A2, W2);
        vecs[6]  = mk(0, 3'b000, 3'b111, 3'b000, 3'b000, 1, A2, W2);
        vecs[7]  = mk(0, 3'b000, 3'b111, 3'b000, 3'b000, 1, A2, W2);
        vecs[8]  = mk(0, 3'b111, 3'b111, 3'b001, 3'b000, 1, A0, W0);
        vecs[9]  = mk(0, 3'b111, 3'b111, RR ? 3'b010 : 3'b001, 3'b000, 1,
                      RR ? A1 : A0, RR ? W1 : W0);
        vecs[10] = mk(0, 3'b111, 3'b111, RR ? 3'b100 : 3'b001, 3'b001, 1,
                      RR ? A2 : A0, RR ? W2 : W0);
        vecs[11] = mk(0, 3'b111, 3'b111, 3'b001, RR ? 3'b010 : 3'b001, 1, A0, W0);
        vecs[12] = mk(0, 3'b000, 3'b111, 3'b000, RR ? 3'b100 : 3'b001, 1, A0, W0);
        vecs[13] = mk(0, 3'b000, 3'b111, 3'b000, 3'b001, 1, A0, W0);
        vecs[14] = mk(0, 3'b000, 3'b111, 3'b000, 3'b000, 1, A0, W0);
        vecs[15] = mk(0, 3'b010, 3'b111, 3'b010, 3'b000, 1, A1, W1);
        vecs[16] = mk(1, 3'b000, 3'b111, 3'b000, 3'b000, 1, 18'h0, 16'h0);
        vecs[17] = mk(0, 3'b000, 3'b111, 3'b000, 3'b000, 1, 18'h0, 16'h0);
        vecs[18] = mk(0, 3'b000, 3'b111, 3'b000, 3'b000, 1, 18'h0, 16'h0);

        for (int i = 0; i < 19; i++) begin
            rst = vecs[i].rst; req = vecs[i].req; we_n = vecs[i].we_n; lock = '0;
            step();
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
            chk($sformatf("v%0d_rdv", i), 32'(rd_valid), 32'(vecs[i].exp_rdv));
            chk($sformatf("v%0d_we_n", i), 32'(sram_we_n), 32'(vecs[i].exp_we_n));
            chk($sformatf("v%0d_addr", i), 32'(sram_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("v%0d_wdata", i), 32'(sram_wdata), 32'(vecs[i].exp_wdata));
        end

        // Lock burst: requester 2 takes ownership, then holds it for 10 grants with 1 waiting.
        we_n = 3'b111;
        req = 3'b100; lock = 3'b100;
        step();
        chk("burst_gnt0", 32'(gnt), 32'(3'b100));
        for (int k = 1; k < 10; k++) begin
            req = 3'b110; lock = 3'b100;
            step();
            chk($sformatf("burst_gnt%0d", k), 32'(gnt), 32'(3'b100));
            if (k >= 2) chk($sformatf("burst_rdv%0d", k), 32'(rd_valid), 32'(3'b100));
        end
        req = 3'b010; lock = 3'b000;
        step();
        chk("burst_release", 32'(gnt), 32'(3'b010));
        req = '0;
        step(); step(); step();

        // Starvation: requester 1 holds lock forever, requester 0 waits for the forced release.
        req = 3'b010; lock = 3'b010;
        step();
        chk("starv_first", 32'(gnt), 32'(3'b010));
        n1 = (gnt == 3'b010) ? 1 : 0;
        saw0 = 1'b0; bad_oh = 0;
        req = 3'b011;
        for (int c = 0; c < 200; c++) begin
            step();
            if (gnt == 3'b001) begin
                saw0 = 1'b1;
                break;
            end else if (gnt == 3'b010) n1++;
            else bad_oh++;
        end
        chk("starv_release_seen", 32'(saw0), 32'd1);
        chk("starv_gnt1_count", 32'(n1), 32'd64);
        chk("starv_onehot", 32'(bad_oh), 32'd0);
        req = 3'b010;
        step();
        chk("starv_regain", 32'(gnt), 32'(3'b010));

        // Reset while owned must drop ownership.
        rst = 1'b1;
        step();
        chk("rst_owned_gnt", 32'(gnt), 32'd0);
        chk("rst_owned_we_n", 32'(sram_we_n), 32'd1);
        rst = 1'b0; req = 3'b011; lock = 3'b010;
        step();
        chk("rst_back_idle", 32'(gnt), 32'(3'b001));
        req = '0; lock = '0;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters (index 0 = UART loader, 1 = Milestone 1, 2 = Milestone 2).
REQ-002 Parameter MAX_LOCK, default 64, maximum consecutive locked grants before forced re-arbitration.
REQ-003 Clock_50  input  1  system clock; all logic on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NUM_REQ  per-requester access request, level-held until granted.
REQ-006 lock  input  NUM_REQ  per-requester request to keep ownership on following cycles.
REQ-007 we_n  input  NUM_REQ  per-requester write enable (0 = write).
REQ-008 addr  input  NUM_REQ x 18  per-requester SRAM word address.
REQ-009 wdata  input  NUM_REQ x 16  per-requester write data.
REQ-010 gnt  output  NUM_REQ  one-hot pulse; the access is on the SRAM bus this cycle.
REQ-011 rd_valid  output  NUM_REQ  one-hot pulse; SRAM_read_data belongs to this requester this cycle.
REQ-012 SRAM_address  output  18  registered address to the SRAM controller.
REQ-013 SRAM_write_data  output  16  registered write data.
REQ-014 SRAM_we_n  output  1  registered write enable, active low.
REQ-015 SRAM_read_data  input  16  SRAM controller read data, valid 2 cycles after the address.

Function
REQ-016 The arbiter selects a winner in cycle t and drives its addr/wdata/we_n on the SRAM outputs with gnt[winner]=1 in cycle t+1.
REQ-017 At most one gnt bit is high per cycle, and a bit is only high if the matching req was high in cycle t.
REQ-018 The FSM has states S_ARB_IDLE (no owner) and S_ARB_OWNED (owner holds lock).
REQ-019 From S_ARB_IDLE, a winner with lock=1 moves the FSM to S_ARB_OWNED; otherwise it stays in S_ARB_IDLE.
REQ-020 In S_ARB_OWNED, the owner wins every cycle while req&lock stay high; req or lock low returns to S_ARB_IDLE and re-arbitrates in the same cycle.
REQ-021 A 7-bit lock counter increments per owned grant; when it reaches MAX_LOCK with any other req pending, ownership is released and the owner becomes lowest priority.
REQ-022 With no granted access in a cycle, SRAM_we_n=1 and SRAM_address holds its last value.
REQ-023 A 2-stage {valid, id} pipeline tags each granted read; rd_valid[id] pulses exactly 2 cycles after its gnt.
REQ-024 Writes produce no rd_valid.
REQ-025 Ownership changes never drop or duplicate in-flight rd_valid tags.

Reset
REQ-026 While Reset=1 (synchronous): gnt=0, rd_valid=0, pipeline valid bits=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, state=S_ARB_IDLE, lock counter=0, round-robin pointer=0.
REQ-027 Reset asserted mid-burst aborts the burst; in-flight read tags are discarded and no rd_valid fires after reset.

Configuration
REQ-028 SRAM_ARB_RR_EN defined: unlocked arbitration is round-robin, starting the search at the index after the last winner.
REQ-029 SRAM_ARB_RR_EN undefined: unlocked arbitration is fixed priority, lowest index wins; MAX_LOCK forced release still applies.

Structure
REQ-030 Package sram_arb_pkg holds the state enum, SRAM_ADDR_W=18, SRAM_DATA_W=16, SRAM_RD_LATENCY=2, and the default MAX_LOCK.
REQ-031 The winner-selection logic (RR/priority plus mask) is the sub-module sram_arb_select; the FSM, registers and read-tag pipeline stay in sram_arbiter.

Verification
REQ-032 Single read: req[1] with addr=18'h0100, no lock -> SRAM_address=0x0100 with gnt[1] one cycle later, then rd_valid[1] 2 cycles after gnt.
REQ-033 Contention with RR_EN: req=3'b111 held, no lock -> gnt sequence 0,1,2,0,...; without RR_EN -> gnt[0] every cycle.
REQ-034 Lock burst: req[2]/lock[2] held for 10 cycles with req[1] pending -> 10 consecutive gnt[2], then gnt[1] in the next cycle.
REQ-035 Starvation: lock[1] held indefinitely with req[0] pending, MAX_LOCK=64 -> gnt[0] after exactly 64 gnt[1].
REQ-036 Write: req[2], we_n[2]=0, addr=146944, wdata=0xABCD -> SRAM_we_n=0 with that address/data for 1 cycle, no rd_valid.
REQ-037 Reset mid-read: assert Reset the cycle after gnt[1] for a read -> rd_valid stays 0, SRAM_we_n=1, state returns to S_ARB_IDLE.
